ysyx_22040237_ifu: RTL



---
 rtl/ysyx_22040237_ifu_pkg.sv | 21 ++
 rtl/ysyx_22040237_pc_reg.sv | 45 ++++
 rtl/ysyx_22040237_ifu.sv | 114 +++++++++++
 3 files changed

// File: rtl/ysyx_22040237_ifu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22040237_ifu_pkg : shared constants and state encodings for the IFU
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ysyx_22040237_ifu_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [XLEN-1:0] DEF_RESET_PC = 64'h8000_0000;
  localparam logic [31:0]     DEF_NOP_INST = 32'h0000_0013;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/ysyx_22040237_pc_reg.sv
// ---------------------------------------------------------------------------
// ysyx_22040237_pc_reg : architectural PC with redirect and sequential step
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ysyx_22040237_pc_reg
  import ysyx_22040237_ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_en,
  input  logic            redir_en,
  input  logic [XLEN-1:0] redir_target,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  // Redirect wins over the sequential step; the low two bits are forced to zero.
  always_comb begin
    pc_d = pc_q;
    if (redir_en) begin
      pc_d = redir_target & ~XLEN'(3);
    end else if (inc_en) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_22040237_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_22040237_ifu : single-outstanding instruction fetch stage feeding decode
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ysyx_22040237_ifu
  import ysyx_22040237_ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0]     NOP_INST = DEF_NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic            fetch_err
);

  logic [1:0]  state_d, state_q;
  logic        drop_d, drop_q;
  logic [31:0] inst_d, inst_q;
  logic        fetch_err_d, fetch_err_q;
  logic        redir;
  logic        inc_en;

  assign redir  = redirect_valid && (state_q != S_BOOT);
  assign inc_en = (state_q == S_OUT) && inst_ready;

  ysyx_22040237_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .inc_en       (inc_en),
    .redir_en     (redir),
    .redir_target (redirect_target),
    .pc           (pc)
  );

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    inst_d      = inst_q;
    fetch_err_d = fetch_err_q | (redir && (redirect_target[1:0] != 2'b00));
    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        // A redirect racing the handshake leaves the old fetch in flight.
        if (imem_req_ready) begin
          state_d = S_WAIT;
          drop_d  = redir;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          drop_d = 1'b0;
          if (drop_q || redir) begin
            state_d = S_REQ;
          end else begin
            inst_d  = imem_resp_data;
            state_d = S_OUT;
          end
        end else if (redir) begin
          drop_d = 1'b1;
        end
      end
      S_OUT: begin
        if (redir || inst_ready) begin
          inst_d  = NOP_INST;
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_BOOT;
      drop_q      <= 1'b0;
      inst_q      <= NOP_INST;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      inst_q      <= inst_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state_q == S_OUT);
  assign inst           = inst_q;
  assign fetch_err      = fetch_err_q;

`ifndef SYNTHESIS
  resp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (state_q == S_WAIT));
`endif

endmodule

`default_nettype wire
